uart_resp_arbiter: RTL and testbench



---
 rtl/uart_resp_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_resp_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_resp_arbiter.sv
// Round-robin arbiter sharing one UART response channel between NUM_REQ requesters.
// Optional WAIT-state watchdog with sticky tx_err enabled by defining RESP_TIMEOUT_EN.
module uart_resp_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned TO_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic                   busy_o,
    output logic                   send_resp_o,
    output logic [7:0]             resp_o,
    input  logic                   resp_sent_i,
    input  logic                   clr_err_i,
    output logic                   tx_err_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StAck} state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               send_q, send_d;
    logic [7:0]         resp_q, resp_d;
    logic               rs_prev_q;
    logic               grant_valid;
    logic [IdxW-1:0]    grant_idx;
    logic               sent_rise;

    assign sent_rise = resp_sent_i && !rs_prev_q;

    // Scan from the highest offset down so the first set index after ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
                grant_valid = 1'b1;
                grant_idx   = IdxW'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

`ifdef RESP_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        err_set;
`else
    logic        unused_clr;
    logic [31:0] unused_to;
    assign unused_clr = clr_err_i;
    assign unused_to  = TO_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        ack_d   = '0;
        busy_d  = busy_q;
        send_d  = 1'b0;
        resp_d  = resp_q;
`ifdef RESP_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_set = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    owner_d = grant_idx;
                    resp_d  = req_data_i[8*int'(grant_idx) +: 8];
                    busy_d  = 1'b1;
                    send_d  = 1'b1;
                    state_d = StSend;
                end
            end
            StSend: begin
                state_d = StWait;
`ifdef RESP_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWait: begin
                if (sent_rise) begin
                    ack_d   = NUM_REQ'(1) << owner_q;
                    state_d = StAck;
                end
`ifdef RESP_TIMEOUT_EN
                else if (cnt_q == TO_CYCLES - 1) begin
                    // Release the requester anyway so a dead UART cannot stall it.
                    err_set = 1'b1;
                    ack_d   = NUM_REQ'(1) << owner_q;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            StAck: begin
                busy_d  = 1'b0;
                ptr_d   = IdxW'((int'(owner_q) + 1) % NUM_REQ);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
`ifdef RESP_TIMEOUT_EN
        err_d = err_set ? 1'b1 : (clr_err_i ? 1'b0 : err_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            owner_q   <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            send_q    <= 1'b0;
            resp_q    <= 8'h00;
            rs_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            send_q    <= send_d;
            resp_q    <= resp_d;
            rs_prev_q <= resp_sent_i;
        end
    end

`ifdef RESP_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign tx_err_o = err_q;
`else
    assign tx_err_o = 1'b0;
`endif

    assign ack_o       = ack_q;
    assign busy_o      = busy_q;
    assign send_resp_o = send_q;
    assign resp_o      = resp_q;

endmodule

// File: tb/tb_uart_resp_arbiter.sv
// Directed self-checking bench for uart_resp_arbiter (3 requesters, TO_CYCLES=8).
module tb_uart_resp_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic [2:0]  ack;
    logic        busy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_sent;
    logic        clr_err;
    logic        tx_err;

    int n_tests = 0;
    int n_fail  = 0;

    uart_resp_arbiter #(
        .NUM_REQ   (3),
        .TO_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .req_data_i  (req_data),
        .ack_o       (ack),
        .busy_o      (busy),
        .send_resp_o (send_resp),
        .resp_o      (resp),
        .resp_sent_i (resp_sent),
        .clr_err_i   (clr_err),
        .tx_err_o    (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_send(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (send_resp) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One full transfer: grant, one-cycle strobe, done edge, ack, requester drops req.
    task automatic serve(input string tag, input logic [7:0] exp_byte, input logic [2:0] exp_ack);
        bit ok;
        wait_send(ok);
        check_eq({tag, "_send"}, 32'(ok), 32'd1);
        check_eq({tag, "_resp"}, 32'(resp), 32'(exp_byte));
        tick();
        check_eq({tag, "_send1cyc"}, 32'(send_resp), 32'd0);
        tick();
        resp_sent = 1'b1;
        tick();
        check_eq({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        req       = req & ~ack;
        resp_sent = 1'b0;
        tick();
        check_eq({tag, "_ackoff"}, 32'(ack), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit       ok;
        logic [2:0] acc;
        int       n;

        rst_n     = 1'b0;
        req       = 3'b000;
        req_data  = 24'h0;
        resp_sent = 1'b0;
        clr_err   = 1'b0;
        tick();
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_send", 32'(send_resp), 32'd0);
        check_eq("rst_resp", 32'(resp), 32'h00);
        check_eq("rst_err", 32'(tx_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request, done edge 10 cycles into the transfer.
        req_data = 24'h0000A5;
        req      = 3'b001;
        tick();
        check_eq("t1_send", 32'(send_resp), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_resp", 32'(resp), 32'hA5);
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            acc = acc | ack;
        end
        check_eq("t1_noack", 32'(acc), 32'd0);
        check_eq("t1_hold", 32'(resp), 32'hA5);
        resp_sent = 1'b1;
        tick();
        check_eq("t1_ack", 32'(ack), 32'b001);
        req       = 3'b000;
        resp_sent = 1'b0;
        tick();
        check_eq("t1_ackoff", 32'(ack), 32'd0);
        check_eq("t1_busyoff", 32'(busy), 32'd0);

        // Round robin with all three requesting and re-raising.
        do_reset();
        req_data = 24'h332211;
        req      = 3'b111;
        serve("rr0", 8'h11, 3'b001);
        req = 3'b111;
        serve("rr1", 8'h22, 3'b010);
        req = 3'b111;
        serve("rr2", 8'h33, 3'b100);
        req = 3'b111;
        serve("rr3", 8'h11, 3'b001);
        req = 3'b000;

        // ptr=2 after serving requester 1; 0 must win over 1.
        req = 3'b010;
        serve("w0", 8'h22, 3'b010);
        req = 3'b011;
        serve("w1", 8'h11, 3'b001);
        serve("w2", 8'h22, 3'b010);

        // Stale done level on WAIT entry must not complete the transfer.
        req       = 3'b100;
        resp_sent = 1'b1;
        wait_send(ok);
        check_eq("st_send", 32'(ok), 32'd1);
        check_eq("st_resp", 32'(resp), 32'h33);
        acc = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acc = acc | ack;
        end
        check_eq("st_noack", 32'(acc), 32'd0);
        check_eq("st_busy", 32'(busy), 32'd1);
        resp_sent = 1'b0;
        tick();
        check_eq("st_noack2", 32'(ack), 32'd0);
        resp_sent = 1'b1;
        tick();
        check_eq("st_ack", 32'(ack), 32'b100);
        req       = 3'b000;
        resp_sent = 1'b0;
        tick();

        // Reset during WAIT: immediate abort, ptr back to 0.
        req = 3'b001;
        serve("pre5", 8'h11, 3'b001);
        req = 3'b011;
        wait_send(ok);
        check_eq("r5_resp", 32'(resp), 32'h22);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("r5_send", 32'(send_resp), 32'd0);
        check_eq("r5_ack", 32'(ack), 32'd0);
        check_eq("r5_busy", 32'(busy), 32'd0);
        check_eq("r5_resp0", 32'(resp), 32'h00);
        tick();
        rst_n = 1'b1;
        serve("r5a", 8'h11, 3'b001);
        serve("r5b", 8'h22, 3'b010);

        // No done edge at all.
        req = 3'b001;
        wait_send(ok);
        check_eq("to_send", 32'(ok), 32'd1);
        tick();
`ifdef RESP_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (ack != 3'b000) break;
        end
        check_eq("to_lat", 32'(n), 32'd8);
        check_eq("to_ack", 32'(ack), 32'b001);
        check_eq("to_err", 32'(tx_err), 32'd1);
        req = 3'b000;
        tick();
        check_eq("to_sticky", 32'(tx_err), 32'd1);
        check_eq("to_idle", 32'(busy), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check_eq("to_clr", 32'(tx_err), 32'd0);
`else
        n   = 0;
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            acc = acc | ack;
            n++;
        end
        check_eq("nt_noack", 32'(acc), 32'd0);
        check_eq("nt_busy", 32'(busy), 32'd1);
        check_eq("nt_err", 32'(tx_err), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check_eq("nt_err2", 32'(tx_err), 32'd0);
        resp_sent = 1'b1;
        tick();
        check_eq("nt_ack", 32'(ack), 32'b001);
        req       = 3'b000;
        resp_sent = 1'b0;
        tick();
        check_eq("nt_idle", 32'(busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
